// File: rtl/bp_group_packer.sv
// BP-mode ECG group packer: 4-bit header plus four variable-width sample fields, MSB-first, into W-bit words.
// Optional BP_PACK_STATS_EN enables the wrapping completed-group counter on group_count.
module bp_group_packer #(
   parameter int unsigned J = 10,
   parameter int unsigned W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [J-1:0] sample_1,
   input  logic signed [J-1:0] sample_2,
   input  logic signed [J-1:0] sample_3,
   input  logic signed [J-1:0] sample_4,
   input  logic [3:0]          bits_req,
   input  logic [1:0]          ecgidx,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        out_word,
   output logic                flush_done,
   output logic [15:0]         group_count
);
   localparam int unsigned AW = 2 * W;
   localparam int unsigned CW = $clog2(AW + 1);
   localparam int unsigned FW = J + 1;
   localparam int unsigned HW = 4;

   typedef enum logic [2:0] {IDLE, HDR, S1, S2, S3, S4, FLUSH} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d, acc_b;
   logic [CW-1:0] cnt_q, cnt_d, cnt_b;
   logic          flush_pend_q, flush_pend_d;
   logic          in_ready_q, in_ready_d;
   logic          flush_done_q, flush_done_d;
   logic [J-1:0]  smp_q [4];
   logic [3:0]    br_q;
   logic [1:0]    ei_q;

   logic          pop, app_ok, accept;
   logic [J-1:0]  s_sel, mag;
   logic [FW-1:0] lmask, fval, f_la;
   logic [CW-1:0] flen;
   logic [AW-1:0] ins;

   assign out_valid  = (cnt_q >= CW'(W));
   assign out_word   = acc_q[AW-1 -: W];
   assign pop        = out_valid && out_ready;
   assign app_ok     = (cnt_q < CW'(W)) || pop;
   assign in_ready   = in_ready_q && !flush;
   assign flush_done = flush_done_q;

   // Field value and width for the current state, left-aligned then placed after the valid bits
   always_comb begin
      s_sel = '0;
      case (state_q)
         S1:      s_sel = smp_q[0];
         S2:      s_sel = smp_q[1];
         S3:      s_sel = smp_q[2];
         S4:      s_sel = smp_q[3];
         default: s_sel = '0;
      endcase
      mag   = s_sel[J-1] ? J'(-s_sel) : s_sel;
      lmask = FW'((FW'(1) << br_q) - FW'(1));
      fval  = '0;
      flen  = '0;
      if (state_q == HDR) begin
         fval = FW'(br_q);
         flen = CW'(HW);
      end else if (32'(br_q) > J) begin
         fval = FW'(s_sel);
         flen = CW'(J);
      end else if (br_q != 4'd0) begin
         if (ei_q == 2'd3) begin
            fval = FW'(s_sel) & lmask;
            flen = CW'(br_q);
         end else begin
            fval = (FW'(s_sel[J-1]) << br_q) | (FW'(mag) & lmask);
            flen = CW'(br_q) + CW'(1);
         end
      end
      f_la = fval << (CW'(FW) - flen);
      ins  = {f_la, {(AW-FW){1'b0}}} >> cnt_b;
   end

   // Next-state: word pop first, then at most one field append or flush padding
   always_comb begin
      state_d      = state_q;
      acc_b        = pop ? (acc_q << W) : acc_q;
      cnt_b        = pop ? (cnt_q - CW'(W)) : cnt_q;
      acc_d        = acc_b;
      cnt_d        = cnt_b;
      flush_pend_d = flush_pend_q || flush;
      accept       = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush_pend_q || flush) begin
               state_d = FLUSH;
            end else if (in_valid && in_ready) begin
               accept  = 1'b1;
               state_d = HDR;
            end
         end
         HDR, S1, S2, S3, S4: begin
            if (app_ok) begin
               acc_d = acc_b | ins;
               cnt_d = cnt_b + flen;
               case (state_q)
                  HDR:     state_d = S1;
                  S1:      state_d = S2;
                  S2:      state_d = S3;
                  S3:      state_d = S4;
                  default: state_d = IDLE;
               endcase
            end
         end
         FLUSH: begin
            if (cnt_q == '0) begin
               state_d      = IDLE;
               flush_pend_d = flush;
            end else if ((cnt_b & CW'(W-1)) != '0) begin
               cnt_d = (cnt_b | CW'(W-1)) + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d   = (state_d == IDLE) && !flush_pend_d;
      flush_done_d = (state_d == FLUSH) && (cnt_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         in_ready_q   <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         in_ready_q   <= in_ready_d;
         flush_done_q <= flush_done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) smp_q[i] <= '0;
         br_q <= '0;
         ei_q <= '0;
      end else if (accept) begin
         smp_q[0] <= sample_1;
         smp_q[1] <= sample_2;
         smp_q[2] <= sample_3;
         smp_q[3] <= sample_4;
         br_q     <= bits_req;
         ei_q     <= ecgidx;
      end
   end

`ifdef BP_PACK_STATS_EN
   logic        grp_done;
   logic [15:0] grp_cnt_q;

   assign grp_done = (state_q == S4) && app_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) grp_cnt_q <= '0;
      else if (grp_done) grp_cnt_q <= grp_cnt_q + 16'd1;
   end

   assign group_count = grp_cnt_q;
`else
   assign group_count = '0;
`endif

endmodule

// File: tb/tb_bp_group_packer.sv
// Directed bench for bp_group_packer: table of single-group packings plus stall, flush and reset sequences.
module tb_bp_group_packer;
   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready;
   logic signed [9:0] sample_1, sample_2, sample_3, sample_4;
   logic [3:0]        bits_req;
   logic [1:0]        ecgidx;
   logic              flush, out_valid, out_ready, flush_done;
   logic [15:0]       out_word, group_count;

   always #5 clk = ~clk;

   bp_group_packer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sample_1(sample_1), .sample_2(sample_2), .sample_3(sample_3), .sample_4(sample_4),
      .bits_req(bits_req), .ecgidx(ecgidx), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .flush_done(flush_done), .group_count(group_count)
   );

   typedef struct {
      string       name;
      int          s1, s2, s3, s4;
      int          br, ei, nw;
      logic [47:0] w;
   } vec_t;

   vec_t        vt [7];
   logic [15:0] wq [$];
   int          done_cnt = 0;
   int          nchk = 0;
   int          nfail = 0;

   // Words taken by downstream and flush_done pulses, recorded away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) wq.push_back(out_word);
         if (flush_done) done_cnt++;
      end
   end

   function automatic vec_t mkv(input string nm, input int a0, input int a1, input int a2,
                                input int a3, input int br, input int ei, input int nw,
                                input logic [47:0] w);
      vec_t v;
      v.name = nm; v.s1 = a0; v.s2 = a1; v.s3 = a2; v.s4 = a3;
      v.br = br; v.ei = ei; v.nw = nw; v.w = w;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_group(input int a0, input int a1, input int a2, input int a3,
                             input int br, input int ei);
      bit got = 1'b0;
      @(posedge clk); #1;
      sample_1 = 10'(a0); sample_2 = 10'(a1); sample_3 = 10'(a2); sample_4 = 10'(a3);
      bits_req = 4'(br); ecgidx = 2'(ei); in_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (in_ready) begin got = 1'b1; break; end
      end
      if (got) @(posedge clk);
      #1 in_valid = 1'b0;
      if (!got) chk("accept_timeout", 32'(got), 1);
   endtask

   task automatic pulse_flush();
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string nm);
      bit got = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         if (done_cnt > d0) begin got = 1'b1; break; end
      end
      chk({nm, "_flush_done"}, 32'(got), 1);
   endtask

   task automatic check_words(input string nm, input int b, input int nw, input logic [95:0] w);
      chk({nm, "_nwords"}, 32'(wq.size() - b), 32'(nw));
      for (int k = 0; k < nw; k++) begin
         if (b + k < wq.size())
            chk($sformatf("%s_w%0d", nm, k), 32'(wq[b+k]), 32'(w[95-16*k -: 16]));
      end
   endtask

   int          b, d0, lowc, gc_exp;
   logic [15:0] hw;
   bit          stable, seen, got_r;

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      sample_1 = '0; sample_2 = '0; sample_3 = '0; sample_4 = '0;
      bits_req = '0; ecgidx = '0;

      vt[0] = mkv("tc_b2",   1,   -2, 0, -1,  2, 3, 1, 48'h2630_0000_0000);
      vt[1] = mkv("sm_b3",   5,   -3, 0,  7,  3, 0, 2, 48'h35B0_7000_0000);
      vt[2] = mkv("esc_b15", 511, -512, 1, -1, 15, 0, 3, 48'hF7FE_0000_7FF0);
      vt[3] = mkv("tc_b4",   7,   -8, 3, -1,  4, 3, 2, 48'h4783_F000_0000);
      vt[4] = mkv("sm_b1",   1,   -1, 0,  0,  1, 2, 1, 48'h1700_0000_0000);
      vt[5] = mkv("esc_b12", 3,   -4, 0,  0, 12, 3, 3, 48'hC00F_FC00_0000);
      vt[6] = mkv("sm_b10",  -512, 1, 0,  0, 10, 0, 3, 48'hAC00_0040_0000);

      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_word", 32'(out_word), 0);
      chk("rst_flush_done", 32'(flush_done), 0);
      chk("rst_group_count", 32'(group_count), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); chk("rel_ready_first", 32'(in_ready), 0);
      @(negedge clk); chk("rel_ready_then", 32'(in_ready), 1);

      foreach (vt[i]) begin
         b = wq.size(); d0 = done_cnt;
         send_group(vt[i].s1, vt[i].s2, vt[i].s3, vt[i].s4, vt[i].br, vt[i].ei);
         pulse_flush();
         wait_done(d0, vt[i].name);
         check_words(vt[i].name, b, vt[i].nw, {vt[i].w, 48'h0});
      end

      // Two zero-width groups: header only, five busy cycles each
      b = wq.size(); d0 = done_cnt;
      for (int g = 0; g < 2; g++) begin
         send_group(0, 0, 0, 0, 0, 0);
         lowc = 0;
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
            lowc++;
         end
         chk($sformatf("zero_ready_low%0d", g), 32'(lowc), 5);
      end
      pulse_flush();
      wait_done(d0, "zero");
      check_words("zero", b, 1, 96'h0);

      // Flush and a group offered together in IDLE: flush completes first, then the group
      b = wq.size(); d0 = done_cnt;
      @(posedge clk); #1;
      sample_1 = 10'(1); sample_2 = 10'(-2); sample_3 = 10'(0); sample_4 = 10'(-1);
      bits_req = 4'd2; ecgidx = 2'd3; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk); chk("fc_ready_low", 32'(in_ready), 0);
      @(posedge clk); #1 flush = 1'b0;
      wait_done(d0, "fc_first");
      chk("fc_no_word", 32'(wq.size() - b), 0);
      got_r = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin got_r = 1'b1; break; end
      end
      chk("fc_group_accepted", 32'(got_r), 1);
      @(posedge clk); #1 in_valid = 1'b0;
      d0 = done_cnt;
      pulse_flush();
      wait_done(d0, "fc_second");
      check_words("fc", b, 1, {48'h2630_0000_0000, 48'h0});

      // Downstream stalled for 20 cycles across two 10-bit groups
      b = wq.size(); d0 = done_cnt;
      @(posedge clk); #1 out_ready = 1'b0;
      fork
         begin
            send_group(1, 2, 3, 4, 10, 3);
            send_group(-1, -2, -3, -4, 10, 3);
            pulse_flush();
         end
         begin
            stable = 1'b1; seen = 1'b0; hw = '0;
            repeat (20) begin
               @(negedge clk);
               if (out_valid) begin
                  if (!seen) begin hw = out_word; seen = 1'b1; end
                  else if (out_word != hw) stable = 1'b0;
               end
            end
            chk("bp_valid_held", 32'(out_valid), 1);
            chk("bp_word_stable", 32'(stable), 1);
            chk("bp_word_first", 32'(hw), 32'h0000_A004);
            chk("bp_fsm_stalled", 32'(in_ready), 0);
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      wait_done(d0, "bp");
      check_words("bp", b, 6, 96'hA004_0200_C04A_FFFF_EFF7_FC00);

      // Reset in S2 discards buffered bits; packing restarts from bit 0
      @(posedge clk); #1 out_ready = 1'b0;
      send_group(1, 2, 3, 4, 10, 3);
      @(posedge clk); @(posedge clk); #1;
      chk("mr_pre_word", 32'(out_word), 32'h0000_A004);
      rst = 1'b1; #1;
      chk("mr_out_valid", 32'(out_valid), 0);
      chk("mr_out_word", 32'(out_word), 0);
      chk("mr_group_count", 32'(group_count), 0);
      chk("mr_in_ready", 32'(in_ready), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; out_ready = 1'b1;

      b = wq.size(); d0 = done_cnt;
      send_group(1, -2, 0, -1, 2, 3);
      pulse_flush();
      wait_done(d0, "mr_after");
      check_words("mr_after", b, 1, {48'h2630_0000_0000, 48'h0});
      b = wq.size(); d0 = done_cnt;
      send_group(0, 0, 0, 0, 0, 0);
      send_group(0, 0, 0, 0, 0, 1);
      pulse_flush();
      wait_done(d0, "mr_zero");
      check_words("mr_zero", b, 1, 96'h0);
`ifdef BP_PACK_STATS_EN
      gc_exp = 3;
`else
      gc_exp = 0;
`endif
      @(negedge clk);
      chk("mr_groups_after", 32'(group_count), 32'(gc_exp));

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/bp_group_packer.md
Name: bp_group_packer

Overview:
- Downstream of the bits-required stage in the BP-mode ECG encoder.
- Accepts one group of 4 signed residual samples together with its bits_req and ecgidx.
- Serialises the group as a 4-bit header followed by 4 variable-width fields, MSB-first, into 16-bit output words with a valid/ready handshake.
- A flush request zero-pads and emits the final partial word at end of stream.

Parameters:
- J, 10, sample width in bits (signed).
- W, 16, output word width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  group present on sample_1..4, bits_req, ecgidx.
- in_ready  out  1  group accepted when in_valid && in_ready.
- sample_1..sample_4  in  J each  signed residual samples, sample_1 emitted first.
- bits_req  in  4  field width from the bits-required stage; 15 = escape.
- ecgidx  in  2  0..2 = sign-magnitude coding, 3 = two's-complement coding.
- flush  in  1  one-cycle pulse requesting end-of-stream padding.
- out_valid  out  1  out_word valid.
- out_ready  in  1  downstream accepts out_word.
- out_word  out  W  packed bits, first-in bit at MSB.
- flush_done  out  1  one-cycle pulse when the flush has completed.
- group_count  out  16  completed groups (see Optional Feature).

Behaviour:
- Reset: in_ready=0 for the cycle after release, then 1. out_valid=0, out_word=0, flush_done=0, group_count=0, accumulator cleared, bit count acc_cnt=0, FSM in IDLE. Reset mid-group discards all buffered bits.
- Accumulator: 32-bit, left-aligned; acc_cnt counts valid bits (0..32).
- out_valid=1 whenever acc_cnt>=16; out_word is the top 16 valid bits.
- On out_valid && out_ready: shift left by 16, acc_cnt -= 16.
- FSM states: IDLE, HDR, S1, S2, S3, S4, FLUSH.
  - IDLE: in_ready=1 unless a flush is pending. On accept, latch all inputs and go to HDR.
  - Each of HDR and S1..S4 appends exactly one field, then advances; S4 returns to IDLE.
  - A field append happens in a cycle only if acc_cnt<16 or a word is taken that same cycle. Otherwise the state holds (back-pressure).
  - Unloaded throughput: 5 cycles per group; in_ready is low for HDR..S4.
- Field widths:
  - Header: 4 bits = latched bits_req.
  - bits_req=0: no sample fields; S1..S4 still take one cycle each but append 0 bits.
  - ecgidx 0..2 (sign-magnitude), 1<=bits_req<=J: field = sign bit (1 if negative) followed by |sample| in bits_req bits (bits_req+1 bits total).
  - ecgidx=3 (two's complement), 1<=bits_req<=J: field = low bits_req bits of the sample.
  - bits_req=15, or any value >J (escape): field = full J-bit two's complement, for either coding.
- Flush:
  - A flush pulse is latched (flush_pend) in any state and serviced from IDLE, after the current group completes.
  - While flush_pend: in_ready=0.
  - FLUSH: if acc_cnt>0 and not a multiple of 16, zero-pad to the next multiple of 16. Wait until acc_cnt=0, then pulse flush_done for one cycle, clear flush_pend, and return to IDLE.
  - Flush with an empty accumulator: flush_done the cycle after entering FLUSH, with no word emitted.
  - Flush coincident with in_valid in IDLE: the flush wins and the group waits.
- out_word and out_valid are held stable while out_valid && !out_ready.

Optional Feature:
- Macro BP_PACK_STATS_EN.
- Defined: group_count increments (wrapping at 16 bits) on the cycle S4 completes its append.
- Not defined: group_count is tied to 0 and the counter logic is absent.

Test Plan:
- ecgidx=3, bits_req=2, samples 1,-2,0,-1, then flush, out_ready=1 -> one word 0x2630 (bits 0010 01 10 00 11 + 4 pad), then flush_done.
- ecgidx=0, bits_req=3, samples 5,-3,0,7, then flush -> words 0x35B0 then 0x7000, then flush_done.
- bits_req=0 group followed by bits_req=0 group, then flush -> single word 0x0000; in_ready low for 5 cycles after each accept.
- ecgidx=0, bits_req=15, J=10, samples 511,-512,1,-1 -> 44 bits: header 0xF then each sample as 10-bit two's complement; flush -> 3 words, last padded with 4 zero bits.
- out_ready=0 for 20 cycles across two bits_req=10 groups -> out_word held stable, FSM stalls, no bits lost; on release, words match reference packing.
- rst asserted during S2 -> out_valid=0 and acc_cnt=0 immediately; the next group packs from bit 0; group_count=0 (with BP_PACK_STATS_EN, 3 groups -> 3).
